// File: rtl/pc_control.sv
// Fetch PC, N/V/Z flag register and branch resolution for the resolve stage.
// Redirects (jr or taken branch) pulse br_taken and hold flush for FLUSH_CYCLES cycles.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_RUN   | active: flags writable, halt/jr/br accepted, PC advances
//   ST_FLUSH | squashing wrong path; down-counter runs, requests dropped
//   ST_HALT  | halted; PC and flags frozen until reset
module pc_control #(
    parameter int                  PC_WIDTH     = 16,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                  FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                halt,
    input  logic [2:0]          flag_we,
    input  logic                alu_n,
    input  logic                alu_v,
    input  logic                alu_z,
    input  logic                br_valid,
    input  logic [2:0]          br_cond,
    input  logic [PC_WIDTH-1:0] br_pc,
    input  logic [8:0]          br_offset,
    input  logic                jr_valid,
    input  logic [PC_WIDTH-1:0] jr_target,
    output logic [PC_WIDTH-1:0] pc,
    output logic                flag_n,
    output logic                flag_v,
    output logic                flag_z,
    output logic                br_taken,
    output logic                flush,
    output logic                halted
);

    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [2:0]          flags_q, flags_d;   // {N,V,Z}, same order as flag_we
    logic                taken_q, taken_d;

    logic [PC_WIDTH-1:0] br_target;
    logic [PC_WIDTH-1:0] pc_inc;
    logic                cond_true;
    logic                fn, fv, fz;

    assign fn = flags_q[2];
    assign fv = flags_q[1];
    assign fz = flags_q[0];

    assign pc_inc    = pc_q + PC_WIDTH'(1);
    assign br_target = br_pc + PC_WIDTH'(1) + {{(PC_WIDTH-9){br_offset[8]}}, br_offset};

    // Conditions look only at registered flags, never at this cycle's ALU write.
    always_comb begin
        cond_true = 1'b0;
        case (br_cond)
            3'b000:  cond_true = ~fz;
            3'b001:  cond_true = fz;
            3'b010:  cond_true = ~(fz | fn);
            3'b011:  cond_true = fn;
            3'b100:  cond_true = fz | ~fn;
            3'b101:  cond_true = fn | fz;
            3'b110:  cond_true = fv;
            default: cond_true = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        flags_d = flags_q;
        taken_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                for (int i = 0; i < 3; i++) begin
                    if (flag_we[i]) flags_d[i] = (i == 2) ? alu_n : (i == 1) ? alu_v : alu_z;
                end
                if (halt) begin
                    state_d = ST_HALT;
                end else if (jr_valid || (br_valid && cond_true)) begin
                    pc_d    = jr_valid ? jr_target : br_target;
                    taken_d = 1'b1;
                    cnt_d   = CW'(FLUSH_CYCLES);
                    state_d = ST_FLUSH;
                end else if (!stall) begin
                    pc_d = pc_inc;
                end
            end
            ST_FLUSH: begin
                // Counter runs regardless of stall so the flush always completes.
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = ST_RUN;
                if (!stall) pc_d = pc_inc;
            end
            ST_HALT: begin
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            pc_q    <= RESET_VECTOR;
            flags_q <= 3'b000;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            flags_q <= flags_d;
            taken_q <= taken_d;
        end
    end

    assign pc       = pc_q;
    assign flag_n   = flags_q[2];
    assign flag_v   = flags_q[1];
    assign flag_z   = flags_q[0];
    assign br_taken = taken_q;
    assign flush    = (state_q == ST_FLUSH);
    assign halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_control.sv
// Directed bench for pc_control with RESET_VECTOR=0x0100, FLUSH_CYCLES=2.
module tb_pc_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, halt;
    logic [2:0]  flag_we;
    logic        alu_n, alu_v, alu_z;
    logic        br_valid;
    logic [2:0]  br_cond;
    logic [15:0] br_pc;
    logic [8:0]  br_offset;
    logic        jr_valid;
    logic [15:0] jr_target;
    logic [15:0] pc;
    logic        flag_n, flag_v, flag_z, br_taken, flush, halted;

    int checks = 0;
    int errors = 0;

    pc_control #(
        .PC_WIDTH    (16),
        .RESET_VECTOR(16'h0100),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .halt     (halt),
        .flag_we  (flag_we),
        .alu_n    (alu_n),
        .alu_v    (alu_v),
        .alu_z    (alu_z),
        .br_valid (br_valid),
        .br_cond  (br_cond),
        .br_pc    (br_pc),
        .br_offset(br_offset),
        .jr_valid (jr_valid),
        .jr_target(jr_target),
        .pc       (pc),
        .flag_n   (flag_n),
        .flag_v   (flag_v),
        .flag_z   (flag_z),
        .br_taken (br_taken),
        .flush    (flush),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctl(input string tag, input logic [15:0] epc,
                             input logic eflush, input logic etaken);
        check({tag, " pc"}, {16'h0, pc}, {16'h0, epc});
        check({tag, " flush"}, {31'h0, flush}, {31'h0, eflush});
        check({tag, " br_taken"}, {31'h0, br_taken}, {31'h0, etaken});
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; halt = 1'b0; flag_we = 3'b000;
        alu_n = 1'b0; alu_v = 1'b0; alu_z = 1'b0;
        br_valid = 1'b0; br_cond = 3'b000; br_pc = 16'h0; br_offset = 9'h0;
        jr_valid = 1'b0; jr_target = 16'h0;
        #12;
        check_ctl("reset", 16'h0100, 1'b0, 1'b0);
        check("reset flags", {29'h0, flag_n, flag_v, flag_z}, 32'h0);
        check("reset halted", {31'h0, halted}, 32'h0);
        rst = 1'b0;
        check("release pc0", {16'h0, pc}, 32'h0100);
        step(); check("release pc1", {16'h0, pc}, 32'h0101);
        step(); check("release pc2", {16'h0, pc}, 32'h0102);

        // Set Z, then a taken EQ branch 0x0010 + 1 - 3 = 0x000E
        flag_we = 3'b001; alu_z = 1'b1;
        step(); check("set z", {31'h0, flag_z}, 32'h1); check("set z pc", {16'h0, pc}, 32'h0103);
        flag_we = 3'b000; alu_z = 1'b0;
        br_valid = 1'b1; br_cond = 3'b001; br_pc = 16'h0010; br_offset = 9'h1FD;
        step(); check_ctl("beq taken", 16'h000E, 1'b1, 1'b1);
        br_cond = 3'b111; br_pc = 16'h0200; br_offset = 9'h000;
        step(); check_ctl("flush c2", 16'h000F, 1'b1, 1'b0);
        step(); check_ctl("flush done", 16'h0010, 1'b0, 1'b0);
        br_valid = 1'b0;

        // Clear Z; LT branch with same-cycle N write must see old N=0
        flag_we = 3'b001; alu_z = 1'b0;
        step(); check("clear z", {31'h0, flag_z}, 32'h0);
        flag_we = 3'b100; alu_n = 1'b1;
        br_valid = 1'b1; br_cond = 3'b011; br_pc = 16'h0000; br_offset = 9'h000;
        step(); check_ctl("lt hazard", 16'h0012, 1'b0, 1'b0);
        check("lt hazard n", {31'h0, flag_n}, 32'h1);
        flag_we = 3'b000; alu_n = 1'b0; br_valid = 1'b0;

        // jr beats br and overrides stall; stall holds PC during flush, counter still runs
        stall = 1'b1; jr_valid = 1'b1; jr_target = 16'hBEEF;
        br_valid = 1'b1; br_cond = 3'b111; br_pc = 16'h1000;
        step(); check_ctl("jr win", 16'hBEEF, 1'b1, 1'b1);
        jr_valid = 1'b0; br_valid = 1'b0;
        step(); check_ctl("stall flush", 16'hBEEF, 1'b1, 1'b0);
        step(); check_ctl("stall flush end", 16'hBEEF, 1'b0, 1'b0);
        stall = 1'b0;
        step(); check_ctl("after stall", 16'hBEF0, 1'b0, 1'b0);

        // Target wrap: 0xFFFE + 1 + 5 = 0x0004
        br_valid = 1'b1; br_cond = 3'b111; br_pc = 16'hFFFE; br_offset = 9'h005;
        step(); check_ctl("wrap target", 16'h0004, 1'b1, 1'b1);
        br_valid = 1'b0;
        step(); step(); check_ctl("wrap settle", 16'h0006, 1'b0, 1'b0);

        // Sequential PC wraps all-ones to zero
        jr_valid = 1'b1; jr_target = 16'hFFFF;
        step(); check_ctl("jr ffff", 16'hFFFF, 1'b1, 1'b1);
        jr_valid = 1'b0;
        step(); check_ctl("pc wrap", 16'h0000, 1'b1, 1'b0);
        step(); check_ctl("pc wrap+1", 16'h0001, 1'b0, 1'b0);

        // Halt at 0x0020 beats a taken branch; further writes ignored
        jr_valid = 1'b1; jr_target = 16'h0020;
        step(); jr_valid = 1'b0; stall = 1'b1;
        step(); step(); check_ctl("park 0x20", 16'h0020, 1'b0, 1'b0);
        stall = 1'b0; halt = 1'b1;
        br_valid = 1'b1; br_cond = 3'b111; br_pc = 16'h0000; br_offset = 9'h000;
        step(); check_ctl("halt", 16'h0020, 1'b0, 1'b0);
        check("halted", {31'h0, halted}, 32'h1);
        halt = 1'b0; br_valid = 1'b0;
        flag_we = 3'b111; alu_n = 1'b0; alu_v = 1'b1; alu_z = 1'b1;
        jr_valid = 1'b1; jr_target = 16'h1234;
        step(); check_ctl("halt hold", 16'h0020, 1'b0, 1'b0);
        check("halt flags", {29'h0, flag_n, flag_v, flag_z}, 32'h4);
        check("halt stays", {31'h0, halted}, 32'h1);
        flag_we = 3'b000; jr_valid = 1'b0;

        rst = 1'b1; #1;
        check_ctl("rst from halt", 16'h0100, 1'b0, 1'b0);
        check("rst halted", {31'h0, halted}, 32'h0);
        check("rst flags", {29'h0, flag_n, flag_v, flag_z}, 32'h0);
        rst = 1'b0;
        step(); check("resume", {16'h0, pc}, 32'h0101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
